muldiv_div_ctrl: RTL
====================

# muldiv_div_ctrl

Sequencer for the RV32M divide instructions (DIV, DIVU, REM, REMU). It sits directly in front of the 32-bit restoring unsigned divider core and performs four jobs:
- accepts requests from the execute stage;
- resolves divide-by-zero and signed overflow without using the core;
- converts signed operands to magnitudes, launches the core and waits for it;
- applies sign correction and returns one 32-bit result with a single-cycle valid pulse.

## Interface
Parameters: none (fixed 32-bit datapath).
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active high
- req_valid  in  1  request present; sampled only when req_ready=1
- req_ready  out  1  high only in IDLE with core_busy=0
- req_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1  in  32  dividend
- rs2  in  32  divisor
- resp_valid  out  1  one-cycle pulse, result available
- resp_data  out  32  result; held until next resp_valid
- core_a  out  32  unsigned dividend to core; registered
- core_b  out  32  unsigned divisor to core; registered
- core_start  out  1  core start strobe, exactly one cycle
- core_q  in  32  core quotient
- core_r  in  32  core remainder
- core_busy  in  1  core operation in progress

## Operation
- **States:** IDLE, LOAD, CHECK, RUN, DONE.
- **Accept:** on a rising edge with req_valid && req_ready, the block registers:
  - op: signed = !req_op[0], rem = req_op[1];
  - neg_q = signed && (rs1[31] ^ rs2[31]);
  - neg_r = signed && rs1[31].
- **Special cases** bypass the core: IDLE→DONE, and resp_data is loaded at the same edge.
  - rs2==0: quotient = 0xFFFFFFFF; remainder = rs1. Applies to both signed and unsigned ops.
  - Signed op with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - Divide-by-zero takes precedence over overflow.
- **Normal path:** IDLE→LOAD.
  - core_a = signed && rs1[31] ? -rs1 : rs1, and core_b is formed the same way from rs2.
  - Negation is 32-bit two's complement, so 0x80000000 maps to 0x80000000 (a valid unsigned magnitude).
- **LOAD:** core_start=1 for this one cycle, then →CHECK.
- **CHECK:**
  - core_busy=1 →RUN.
  - core_busy=0 means the core suppressed start because core_a<core_b. Its outputs are combinationally valid (q=0, r=core_a), so capture them now and go →DONE.
- **RUN:** wait while core_busy=1. On the first cycle with core_busy=0, capture and go →DONE.
- **Capture rule:**
  - Base value: v = rem ? core_r : core_q.
  - resp_data = (rem ? neg_r : neg_q) ? -v : v.
  - Result: remainder takes the sign of the dividend; quotient rounds toward zero.
- **DONE:** resp_valid=1 for one cycle, then →IDLE.
- **Operand hold:** core_a and core_b stay constant from LOAD until DONE is left. The core reads b every iteration and compares a<b combinationally, so these must not change mid-operation.
- **Input changes:** the inputs rs1, rs2 and req_op are ignored outside the accept edge.

## Timing
- **Reset values:**

  | Signal | Value |
  |---|---|
  | state | IDLE |
  | resp_valid | 0 |
  | resp_data | 0 |
  | core_start | 0 |
  | core_a | 0 |
  | core_b | 0 |
  | internal op/sign flags | 0 |

- **req_ready during and after reset:** req_ready=0 while rst=1. After reset it is 1, provided core_busy=0.
- **Latency** is counted from the accept edge, i.e. the cycle in which resp_valid=1:
  - special case: cycle 1;
  - magnitude a<b: cycle 3;
  - full core run (1 Prep + 32 Loop cycles): cycle 36.
- **Throughput:** a new request may be accepted in the cycle after resp_valid, once the block is back in IDLE. There is no back-pressure on the response.
- **Reset mid-operation:** the controller returns to IDLE and no resp_valid is issued. This block does not reset the core, so req_ready stays 0 until core_busy falls. A stale core result is never reported.
- **Reset priority:** rst=1 coincident with an accept wins; the request is dropped.

## Test plan
- DIVU rs1=100, rs2=7: resp_data=14, resp_valid 36 cycles after accept, core_start high exactly one cycle. REMU with the same operands gives 2.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2: resp_data=0xFFFFFFFD. REM with the same operands gives 0xFFFFFFFF. DIV 7/-2 gives 0xFFFFFFFD; REM 7/-2 gives 1.
- REMU rs1=5, rs2=9: resp_data=5 at cycle 3, core_busy never rises. DIVU with the same operands gives 0 at cycle 3.
- DIV 123/0 gives 0xFFFFFFFF; REM 0xFFFFFF85/0 gives 0xFFFFFF85. Both at cycle 1, core_start never asserted.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0. Both at cycle 1. DIVU with the same operands runs the core and gives 0.
- Assert rst for one cycle in RUN at cycle 10:
  - no resp_valid follows;
  - req_ready stays 0 until core_busy=0;
  - a subsequent DIVU 9/3 returns 3.

Source files
------------

// File: rtl/muldiv_div_ctrl.sv
// RV32M divide sequencer: handles divide-by-zero and signed overflow directly, feeds operand
// magnitudes to the restoring unsigned divider core, and sign-corrects the quotient or remainder.
module muldiv_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_start,
    input  logic [31:0] core_q,
    input  logic [31:0] core_r,
    input  logic        core_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_core_a;
    logic [31:0] r_core_b;
    logic [31:0] r_resp_data;

    logic        w_signed;
    logic        w_rem;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_val;
    logic        w_accept;
    logic        w_core_done;
    logic [31:0] w_capture_val;

    // Two's complement negation when neg is set; 0x80000000 maps onto itself.
    function automatic logic [31:0] f_cond_neg(input logic [31:0] v, input logic neg);
        logic signed [31:0] s;
        s = signed'(v);
        return neg ? unsigned'(-s) : v;
    endfunction

    function automatic logic [31:0] f_mag(input logic signed [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? unsigned'(-v) : unsigned'(v);
    endfunction

    always_comb begin
        w_signed  = ~req_op[0];
        w_rem     = req_op[1];
        w_div0    = (rs2 == 32'd0);
        w_ovf     = w_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
        w_special = w_div0 | w_ovf;
        // Divide-by-zero wins over overflow.
        if (w_div0) begin
            w_special_val = w_rem ? rs1 : 32'hFFFF_FFFF;
        end else begin
            w_special_val = w_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        req_ready     = (r_state == S_IDLE) && !core_busy && !rst;
        w_accept      = req_valid && req_ready;
        w_core_done   = ((r_state == S_CHECK) || (r_state == S_RUN)) && !core_busy;
        w_capture_val = f_cond_neg(r_rem ? core_r : core_q, r_rem ? r_neg_r : r_neg_q);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  w_state_nxt = S_CHECK;
            // A core that stays idle after start saw a<b and already shows q=0, r=a.
            S_CHECK: w_state_nxt = core_busy ? S_RUN : S_DONE;
            S_RUN:   w_state_nxt = core_busy ? S_RUN : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rem       <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_core_a    <= 32'd0;
            r_core_b    <= 32'd0;
            r_resp_data <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rem   <= w_rem;
                r_neg_q <= w_signed && (rs1[31] ^ rs2[31]);
                r_neg_r <= w_signed && rs1[31];
                if (w_special) begin
                    r_resp_data <= w_special_val;
                end else begin
                    // Operands stay frozen until the next accept; the core rereads them every cycle.
                    r_core_a <= f_mag(signed'(rs1), w_signed);
                    r_core_b <= f_mag(signed'(rs2), w_signed);
                end
            end
            if (w_core_done) begin
                r_resp_data <= w_capture_val;
            end
        end
    end

    always_comb begin
        resp_valid = (r_state == S_DONE);
        core_start = (r_state == S_LOAD);
        resp_data  = r_resp_data;
        core_a     = r_core_a;
        core_b     = r_core_b;
    end

endmodule
